// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, 7/8 data bits, optional parity,
// 1/2 stop bits; one-cycle valid strobe with parity and framing error flags.
module uart_rx #(
   parameter int unsigned CLK_FREQ = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] baud_rate,
   input  logic       data_size,
   input  logic       parity_en,
   input  logic [1:0] parity_mode,
   input  logic       stop_bit_size,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

   localparam int unsigned MaxDiv = CLK_FREQ / 9600;
   localparam int unsigned CntW   = $clog2(MaxDiv + 1);

   function automatic logic [CntW-1:0] baud_div(input logic [2:0] code);
      int unsigned baud;
      case (code)
         3'd0:    baud = 9600;
         3'd1:    baud = 19200;
         3'd2:    baud = 38400;
         3'd3:    baud = 57600;
         3'd4:    baud = 115200;
         3'd5:    baud = 230400;
         3'd6:    baud = 460800;
         default: baud = 921600;
      endcase
      return CntW'(CLK_FREQ / baud);
   endfunction

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop1, StStop2, StWaitHigh
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rxs, rxs_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d, div_q, half_m1, div_m1;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d, word;
   logic            size8_q, par_en_q, stop2_q;
   logic [1:0]      par_mode_q;
   logic            perr_pend_q, perr_pend_d, ferr_pend_q, ferr_pend_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
   logic            start_det, tick, last_bit, complete, exp_par;

   assign rxs       = sync_q[1];
   assign start_det = en && (state_q == StIdle) && rxs_prev_q && !rxs;
   assign half_m1   = (div_q >> 1) - CntW'(1);
   assign div_m1    = div_q - CntW'(1);
   assign tick      = (state_q == StStart) ? (cnt_q == half_m1) : (cnt_q == div_m1);
   assign last_bit  = (bit_q == (size8_q ? 3'd7 : 3'd6));
   assign complete  = en && tick &&
                      (((state_q == StStop1) && !stop2_q) || (state_q == StStop2));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sync_q      <= 2'b11;
         rxs_prev_q  <= 1'b1;
         cnt_q       <= '0;
         div_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         size8_q     <= 1'b0;
         par_en_q    <= 1'b0;
         par_mode_q  <= 2'b00;
         stop2_q     <= 1'b0;
         perr_pend_q <= 1'b0;
         ferr_pend_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[0], rx};
         rxs_prev_q  <= rxs;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         perr_pend_q <= perr_pend_d;
         ferr_pend_q <= ferr_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
         // Frame options are frozen for the whole frame
         if (start_det) begin
            div_q      <= baud_div(baud_rate);
            size8_q    <= data_size;
            par_en_q   <= parity_en;
            par_mode_q <= parity_mode;
            stop2_q    <= stop_bit_size;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:     if (start_det) state_d = StStart;
            StStart:    if (tick) state_d = rxs ? StIdle : StData;
            StData:     if (tick && last_bit) state_d = par_en_q ? StParity : StStop1;
            StParity:   if (tick) state_d = StStop1;
            StStop1: begin
               if (tick) begin
                  if (stop2_q) state_d = StStop2;
                  else         state_d = rxs ? StIdle : StWaitHigh;
               end
            end
            StStop2:    if (tick) state_d = rxs ? StIdle : StWaitHigh;
            StWaitHigh: if (rxs) state_d = StIdle;
            default:    state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      word = size8_q ? shift_q : {1'b0, shift_q[7:1]};
      case (par_mode_q)
         2'b11:   exp_par = ~^word;
         2'b10:   exp_par = ^word;
         2'b01:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase

      cnt_d = cnt_q + CntW'(1);
      if (tick || (state_d != state_q) || (state_q == StIdle) || (state_q == StWaitHigh)) begin
         cnt_d = '0;
      end

      bit_d   = '0;
      shift_d = shift_q;
      if (state_q == StData) begin
         bit_d = tick ? bit_q + 3'd1 : bit_q;
         if (tick) shift_d = {rxs, shift_q[7:1]};
      end

      perr_pend_d = perr_pend_q;
      ferr_pend_d = ferr_pend_q;
      if (start_det) begin
         perr_pend_d = 1'b0;
         ferr_pend_d = 1'b0;
      end
      if ((state_q == StParity) && tick) perr_pend_d = (rxs != exp_par);
      if (((state_q == StStop1) || (state_q == StStop2)) && tick && !rxs) ferr_pend_d = 1'b1;

      valid_d = complete;
      data_d  = complete ? word : data_q;
      perr_d  = complete ? perr_pend_q : perr_q;
      ferr_d  = complete ? (ferr_pend_q | ~rxs) : ferr_q;
   end

   always_comb begin
      busy         = state_q inside {StStart, StData, StParity, StStop1, StStop2};
      data         = data_q;
      valid        = valid_q;
      parity_error = perr_q;
      frame_error  = ferr_q;
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a serial frame generator plays the transmitter and a
// frame-level model predicts data and error flags for every frame it sends.
module tb_uart_rx;

   localparam int unsigned ClkFreq = 100000000;

   logic       clk = 1'b0;
   logic       rst, en, data_size, parity_en, stop_bit_size, rx;
   logic [2:0] baud_rate;
   logic [1:0] parity_mode;
   logic [7:0] data;
   logic       valid, parity_error, frame_error, busy;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bz;
   } rec_t;

   rec_t rec_q[$];
   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   uart_rx #(.CLK_FREQ(ClkFreq)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .baud_rate    (baud_rate),
      .data_size    (data_size),
      .parity_en    (parity_en),
      .parity_mode  (parity_mode),
      .stop_bit_size(stop_bit_size),
      .rx           (rx),
      .data         (data),
      .valid        (valid),
      .parity_error (parity_error),
      .frame_error  (frame_error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Every cycle with valid high is one received frame
   always @(negedge clk) begin
      rec_t r;
      if (valid === 1'b1) begin
         r.d  = data;
         r.pe = parity_error;
         r.fe = frame_error;
         r.bz = busy;
         rec_q.push_back(r);
      end
   end

   initial begin
      #(10 * 95000);
      $display("FAIL watchdog: observed no end of test, required finish within 95000 cycles");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_frames(input string tag);
      int n;
      check($sformatf("%s frame count", tag), rec_q.size(), exp_q.size());
      n = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s[%0d] data", tag, i), rec_q[i].d, exp_q[i].d);
         check($sformatf("%s[%0d] parity_error", tag, i), rec_q[i].pe, exp_q[i].pe);
         check($sformatf("%s[%0d] frame_error", tag, i), rec_q[i].fe, exp_q[i].fe);
         check($sformatf("%s[%0d] busy at valid", tag, i), rec_q[i].bz, 1'b0);
      end
      rec_q.delete();
      exp_q.delete();
   endtask

   function automatic int div_of(input logic [2:0] code);
      int bauds[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
      return ClkFreq / bauds[code];
   endfunction

   function automatic logic exp_parity(input logic [7:0] w, input logic [1:0] pm);
      int ones;
      ones = $countones(w);
      case (pm)
         2'b11:   return (ones % 2) == 0;
         2'b10:   return (ones % 2) == 1;
         2'b01:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic bitx(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic set_cfg(input logic [2:0] br, input logic sz8, input logic pen,
                          input logic [1:0] pm, input logic s2);
      baud_rate     = br;
      data_size     = sz8;
      parity_en     = pen;
      parity_mode   = pm;
      stop_bit_size = s2;
   endtask

   // Serialise one frame from the given options and queue its expected outcome
   task automatic send_frame(input logic [7:0] b, input logic [2:0] br, input logic sz8,
                             input logic pen, input logic [1:0] pm, input logic s2,
                             input logic par_flip, input logic [1:0] stop_low,
                             input logic scramble);
      int         div;
      logic [7:0] w;
      logic       p;
      rec_t       e;
      div = div_of(br);
      w   = sz8 ? b : {1'b0, b[6:0]};
      p   = exp_parity(w, pm) ^ par_flip;
      bitx(1'b0, div);
      if (scramble) begin
         baud_rate     = 3'($urandom);
         data_size     = 1'($urandom);
         parity_en     = 1'($urandom);
         parity_mode   = 2'($urandom);
         stop_bit_size = 1'($urandom);
      end
      for (int i = 0; i < (sz8 ? 8 : 7); i++) bitx(w[i], div);
      if (pen) bitx(p, div);
      bitx(!stop_low[0], div);
      if (s2) bitx(!stop_low[1], div);
      e.d  = w;
      e.pe = pen & par_flip;
      e.fe = stop_low[0] | (s2 & stop_low[1]);
      e.bz = 1'b0;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [7:0] b;
      logic [2:0] br;
      logic       sz8, pen, s2, flip;
      logic [1:0] pm, sl;

      rst = 1'b1;
      en  = 1'b1;
      rx  = 1'b1;
      set_cfg(3'd7, 1'b1, 1'b1, 2'b11, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset data", data, 8'h00);
      check("reset valid", valid, 1'b0);
      check("reset parity_error", parity_error, 1'b0);
      check("reset frame_error", frame_error, 1'b0);
      check("reset busy", busy, 1'b0);
      repeat (20) @(negedge clk);

      // 8O1 at code 7, good frame
      send_frame(8'hAA, 3'd7, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
      bitx(1'b1, 216);
      check_frames("t1");

      // bad parity, then the same byte with correct parity
      send_frame(8'h3C, 3'd7, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0);
      bitx(1'b1, 216);
      send_frame(8'h3C, 3'd7, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0);
      bitx(1'b1, 216);
      check_frames("t2");

      // 7N2, second stop low, then a held-low line
      set_cfg(3'd7, 1'b0, 1'b0, 2'b00, 1'b1);
      send_frame(8'h55, 3'd7, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
      bitx(1'b0, 3 * 108);
      check("t3 busy while line held low", busy, 1'b0);
      check_frames("t3a");
      bitx(1'b1, 216);
      send_frame(8'h12, 3'd7, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
      bitx(1'b1, 216);
      check_frames("t3b");

      // short glitch is rejected
      set_cfg(3'd7, 1'b1, 1'b0, 2'b00, 1'b0);
      bitx(1'b0, 10);
      check("t4 busy during glitch", busy, 1'b1);
      bitx(1'b0, 10);
      bitx(1'b1, 300);
      check("t4 busy after glitch", busy, 1'b0);
      check_frames("t4 glitch");

      // reset in the 4th data bit
      b = 8'h5A;
      bitx(1'b0, 108);
      for (int i = 0; i < 3; i++) bitx(b[i], 108);
      bitx(b[3], 54);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t4 rst data", data, 8'h00);
      check("t4 rst valid", valid, 1'b0);
      check("t4 rst parity_error", parity_error, 1'b0);
      check("t4 rst frame_error", frame_error, 1'b0);
      check("t4 rst busy", busy, 1'b0);
      bitx(1'b1, 1500);
      check_frames("t4 rst");

      // back-to-back loopback under every parity mode
      for (int m = 0; m < 4; m++) begin
         set_cfg(3'd7, 1'b1, 1'b1, 2'(m), 1'b0);
         send_frame(8'h00, 3'd7, 1'b1, 1'b1, 2'(m), 1'b0, 1'b0, 2'b00, 1'b0);
         send_frame(8'hFF, 3'd7, 1'b1, 1'b1, 2'(m), 1'b0, 1'b0, 2'b00, 1'b0);
         send_frame(8'hA5, 3'd7, 1'b1, 1'b1, 2'(m), 1'b0, 1'b0, 2'b00, 1'b0);
         bitx(1'b1, 216);
      end
      check_frames("t5");

      // enable dropped mid-frame
      set_cfg(3'd7, 1'b1, 1'b0, 2'b00, 1'b0);
      b = 8'h81;
      bitx(1'b0, 108);
      for (int i = 0; i < 3; i++) bitx(b[i], 108);
      bitx(b[3], 20);
      check("t6 busy before abort", busy, 1'b1);
      en = 1'b0;
      bitx(b[3], 2);
      check("t6 busy after abort", busy, 1'b0);
      bitx(b[3], 86);
      for (int i = 4; i < 8; i++) bitx(b[i], 108);
      bitx(1'b1, 200);
      en = 1'b1;
      bitx(1'b1, 50);
      send_frame(8'h81, 3'd7, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
      bitx(1'b1, 216);
      check_frames("t6");

      // random frames; options scrambled mid-frame
      for (int k = 0; k < 8; k++) begin
         br   = 3'($urandom_range(6, 7));
         sz8  = 1'($urandom);
         pen  = 1'($urandom);
         pm   = 2'($urandom);
         s2   = 1'($urandom);
         b    = 8'($urandom);
         flip = ($urandom_range(0, 3) == 0);
         sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         set_cfg(br, sz8, pen, pm, s2);
         send_frame(b, br, sz8, pen, pm, s2, flip, sl, 1'b1);
         bitx(1'b1, 2 * div_of(br));
      end
      check_frames("rand");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
